// File: rtl/outerprodrc_pkg.sv
// Shared constants and helpers for the rate-coded outer-product tile.
package outerprodrc_pkg;

  localparam int DEF_BITWIDTH    = 4;
  localparam int DEF_ROWNUM      = 2;
  localparam int DEF_COLNUM      = 2;
  localparam int DEF_MAGWIDTH    = DEF_BITWIDTH - 1;
  localparam int DEF_CNTWIDTH    = 2 * DEF_MAGWIDTH;
  localparam int DEF_OUTBITWIDTH = 2 * DEF_MAGWIDTH + 1;

  // Flat PE index; multiply by the accumulator width to get the oData slice base.
  function automatic int outIdx(input int r, input int c, input int colNum);
    return r * colNum + c;
  endfunction

endpackage

// File: rtl/outerprodrc_pe.sv
// One processing element: ANDs a row and a column bitstream and counts the
// coincidences up or down depending on the product sign.
module outerprodrc_pe #(
  parameter int OUTBITWIDTH = 7
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iEn,
  input  logic                   iClr,
  input  logic                   iRowBit,
  input  logic                   iColBit,
  input  logic                   iSgn,
  output logic [OUTBITWIDTH-1:0] oAcc
);

  localparam logic [OUTBITWIDTH-1:0] ONE = OUTBITWIDTH'(1);

  logic prod;

  assign prod = iRowBit & iColBit;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oAcc <= '0;
    end else if (iClr) begin
      oAcc <= '0;
    end else if (iEn && prod) begin
      oAcc <= iSgn ? (oAcc - ONE) : (oAcc + ONE);
    end
  end

endmodule

// File: rtl/outerprodrc_core.sv
// Unary outer-product tile: a shared cycle counter turns sign-magnitude
// operands into deterministic bitstreams feeding a ROWNUM x COLNUM PE grid.
module outerprodrc_core
  import outerprodrc_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int ROWNUM      = DEF_ROWNUM,
  parameter int COLNUM      = DEF_COLNUM,
  parameter int OUTBITWIDTH = 2 * (BITWIDTH - 1) + 1
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iEn,
  input  logic                                 iClr,
  input  logic [ROWNUM*BITWIDTH-1:0]           iData0,
  input  logic [COLNUM*BITWIDTH-1:0]           iData1,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

  localparam int MAGWIDTH = BITWIDTH - 1;
  localparam int CNTWIDTH = 2 * MAGWIDTH;

  logic [CNTWIDTH-1:0] cnt;
  logic                done;
  logic                step;
  logic [ROWNUM-1:0]   rowBit;
  logic [ROWNUM-1:0]   rowSign;
  logic [COLNUM-1:0]   colBit;
  logic [COLNUM-1:0]   colSign;

  assign step = iEn && !done;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (iClr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (step) begin
      cnt <= cnt + CNTWIDTH'(1);
      if (&cnt) begin
        done <= 1'b1;
      end
    end
  end

  // Rows compare against the fast low half, columns against the slow high
  // half, so every (row, col) magnitude pair is enumerated exactly once.
  always_comb begin
    rowBit  = '0;
    rowSign = '0;
    colBit  = '0;
    colSign = '0;
    for (int r = 0; r < ROWNUM; r++) begin
      rowBit[r]  = iData0[r*BITWIDTH +: MAGWIDTH] > cnt[MAGWIDTH-1:0];
      rowSign[r] = iData0[r*BITWIDTH + MAGWIDTH];
    end
    for (int c = 0; c < COLNUM; c++) begin
      colBit[c]  = iData1[c*BITWIDTH +: MAGWIDTH] > cnt[CNTWIDTH-1:MAGWIDTH];
      colSign[c] = iData1[c*BITWIDTH + MAGWIDTH];
    end
  end

  for (genvar r = 0; r < ROWNUM; r++) begin : gRow
    for (genvar c = 0; c < COLNUM; c++) begin : gCol
      outerprodrc_pe #(
        .OUTBITWIDTH(OUTBITWIDTH)
      ) uPe (
        .iClk   (iClk),
        .iRst   (iRst),
        .iEn    (step),
        .iClr   (iClr),
        .iRowBit(rowBit[r]),
        .iColBit(colBit[c]),
        .iSgn   (rowSign[r] ^ colSign[c]),
        .oAcc   (oData[outIdx(r, c, COLNUM)*OUTBITWIDTH +: OUTBITWIDTH])
      );
    end
  end

endmodule

// File: tb/tb_outerprodrc_core.sv
// Self-checking bench for outerprodrc_core with an expected-value queue.
module tb_outerprodrc_core;

  localparam int BW = 4;
  localparam int RN = 2;
  localparam int CN = 2;
  localparam int OW = 2 * (BW - 1) + 1;

  logic              iClk;
  logic              iRst;
  logic              iEn;
  logic              iClr;
  logic [RN*BW-1:0]  iData0;
  logic [CN*BW-1:0]  iData1;
  logic [RN*CN*OW-1:0] oData;

  logic [OW-1:0] exp_q[$];
  int checks;
  int errors;

  outerprodrc_core #(
    .BITWIDTH(BW), .ROWNUM(RN), .COLNUM(CN), .OUTBITWIDTH(OW)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iData0(iData0), .iData1(iData1), .oData(oData)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference: signed count of stream coincidences over the first k cycles.
  function automatic int partialProd(input logic [BW-1:0] a, input logic [BW-1:0] b, input int k);
    int s;
    logic [5:0] cv;
    s = 0;
    for (int i = 0; i < k && i < 64; i++) begin
      cv = 6'(i);
      if ((a[2:0] > cv[2:0]) && (b[2:0] > cv[5:3]))
        s += (a[3] ^ b[3]) ? -1 : 1;
    end
    return s;
  endfunction

  function automatic int fullProd(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int p;
    p = int'(a[2:0]) * int'(b[2:0]);
    return (a[3] ^ b[3]) ? -p : p;
  endfunction

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic push_expected(input int k);
    logic [BW-1:0] a, b;
    for (int r = 0; r < RN; r++)
      for (int c = 0; c < CN; c++) begin
        a = iData0[r*BW +: BW];
        b = iData1[c*BW +: BW];
        if (k >= 64) exp_q.push_back(OW'(fullProd(a, b)));
        else         exp_q.push_back(OW'(partialProd(a, b, k)));
      end
  endtask

  task automatic start_period(input logic [RN*BW-1:0] d0, input logic [CN*BW-1:0] d1);
    iData0 = d0;
    iData1 = d1;
    iEn = 1'b0;
    iClr = 1'b1;
    edges(1);
    iClr = 1'b0;
    iEn = 1'b1;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iData0 = '0; iData1 = '0;
    edges(3);
    iRst = 1'b0;
    edges(1);
    for (int i = 0; i < RN*CN; i++) exp_q.push_back('0);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL reset pe%0d got %0h expected %0h", i, oData[i*OW +: OW], e);
      end
    end
  endtask

  task automatic test_basic;
    start_period({4'b1110, 4'b0010}, {4'b0100, 4'b1100});
    edges(64);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL basic pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
    edges(100);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL hold pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
  endtask

  task automatic test_en_gap;
    start_period({4'b1110, 4'b0010}, {4'b0100, 4'b1100});
    edges(30);
    iEn = 1'b0;
    edges(20);
    push_expected(30);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL en_gap_mid pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
    iEn = 1'b1;
    edges(34);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL en_gap_final pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
  endtask

  task automatic test_extremes;
    start_period({4'b1111, 4'b0111}, {4'b0111, 4'b0111});
    edges(64);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL extremes pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
  endtask

  // Cycle-by-cycle against the reference; zero/negative-zero PEs must stay 0.
  task automatic test_zero;
    start_period({4'b1000, 4'b0011}, {4'b0000, 4'b1101});
    for (int k = 1; k <= 64; k++) begin
      edges(1);
      push_expected(k);
      for (int i = 0; i < RN*CN; i++) begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (oData[i*OW +: OW] !== e) begin
          errors++;
          $display("FAIL zero_k%0d pe%0d got %0d expected %0d", k, i, $signed(oData[i*OW +: OW]), $signed(e));
        end
      end
    end
  endtask

  task automatic test_clear;
    start_period({4'b1110, 4'b0010}, {4'b0100, 4'b1100});
    edges(70);
    iClr = 1'b1;
    edges(1);
    iClr = 1'b0;
    for (int i = 0; i < RN*CN; i++) exp_q.push_back('0);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL clear pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
    edges(64);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL clear_restart pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
  endtask

  task automatic test_async_reset;
    start_period({4'b0111, 4'b1101}, {4'b1011, 4'b0110});
    edges(20);
    #2;
    iRst = 1'b1;
    #1;
    for (int i = 0; i < RN*CN; i++) exp_q.push_back('0);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL async_reset pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
    @(negedge iClk);
    iRst = 1'b0;
    edges(64);
    push_expected(64);
    for (int i = 0; i < RN*CN; i++) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (oData[i*OW +: OW] !== e) begin
        errors++;
        $display("FAIL async_restart pe%0d got %0d expected %0d", i, $signed(oData[i*OW +: OW]), $signed(e));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_en_gap();
    test_extremes();
    test_zero();
    test_clear();
    test_async_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
